regfile_write_decode: RTL and testbench
=======================================

Name: regfile_write_decode

Overview:
- 32-entry register file for the multicycle CPU.
- Its write side is a 5-to-32 one-hot decoder that steers one data word into exactly one of 32 registers. This is the inverse of the 32:1 read-select path.
- Two combinational read ports feed the ALU operand latches.
- Register 0 is hardwired to zero.

Parameters:
- width, 32, data width of every register and of the write and read data ports.
- BYPASS, 0, 1 = a same-cycle write is forwarded to a matching read port; 0 = a read returns the stored value only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- wr_en  input  1  write enable for the current cycle.
- wr_addr  input  5  destination register index.
- wr_data  input  width  data to write.
- rd_addr_a  input  5  read port A index.
- rd_addr_b  input  5  read port B index.
- rd_data_a  output  width  read port A data (combinational).
- rd_data_b  output  width  read port B data (combinational).
- wr_onehot  output  32  decoded write strobe (combinational, for debug and coverage).
- wr_count  output  16  registered count of committed writes, saturating.

Behaviour:
- Storage: regs[1..31], each width bits. regs[0] does not exist as state and always reads 0.
- Decoder: wr_onehot = (wr_en && !reset) ? (1 << wr_addr) : 0, with bit 0 forced to 0. At most one bit is set at any time.
- Write: on the rising edge, if reset = 0 and wr_onehot[k] = 1, then regs[k] <= wr_data. All other registers hold their value.
- Write latency: 1 cycle. A value written at edge N is visible on a read port from edge N onward, combinationally after that edge.
- Read: rd_data_x = (rd_addr_x == 0) ? 0 : regs[rd_addr_x]. The path is purely combinational, with no read enable.
- Bypass:
  - Applies only when BYPASS = 1.
  - Condition: wr_en = 1, reset = 0, wr_addr != 0, and wr_addr == rd_addr_x.
  - When the condition holds, rd_data_x = wr_data in the same cycle, before the edge.
  - It applies to each port independently. Both ports may bypass at once.
- Write to address 0: no state change and no bypass. wr_onehot = 0. wr_count still increments, because the write is architecturally committed as a no-op.
- Reset:
  - When reset = 1 at a rising edge, regs[1..31] <= 0 and wr_count <= 0.
  - Reset has priority over a simultaneous write; that write is dropped.
  - While reset is asserted, wr_onehot = 0 and bypass is suppressed. Read ports show the current register contents.
  - Asserting reset in the middle of a program sequence loses all prior register contents. No partial state is retained.
- wr_count:
  - Increments by 1 at each edge where wr_en = 1 and reset = 0.
  - Saturates at 16'hFFFF and does not wrap.
- Simultaneous events:
  - A read and a write to the same address in the same cycle return the old value when BYPASS = 0, and wr_data when BYPASS = 1.
  - Two read ports at the same address always return identical data.
- X handling: wr_addr and wr_data are don't-care when wr_en = 0. The outputs must not depend on them in that case.
- Reset values: rd_data_a and rd_data_b = 0 (all registers are 0), wr_onehot = 0, wr_count = 0.

Test Plan:
- Reset and write to register 0:
  - Stimulus: reset for 2 cycles, then read all 32 addresses on both ports. Next, write 0xDEADBEEF to r0 and read r0.
  - Response: all reads = 0 and wr_count = 0 after reset. After the r0 write: rd_data = 0, wr_onehot = 0, wr_count = 1.
- Decoder sweep:
  - Stimulus: for k = 1..31, write k*0x01010101 to rk with wr_en = 1, then read back on both ports.
  - Response: wr_onehot == (1 << k) during each write cycle. Each rk reads k*0x01010101 and no other register changes. wr_count = 31.
- Same-cycle read/write, BYPASS = 0:
  - Stimulus: r5 = 0x11, then in one cycle write 0x22 to r5 with rd_addr_a = 5.
  - Response: rd_data_a = 0x11 before the edge and 0x22 after it.
- Same-cycle read/write, BYPASS = 1 (same stimulus):
  - Response: rd_data_a = 0x22 before the edge.
  - Write 0x33 to r0 with rd_addr_a = 0: rd_data_a stays 0.
- Reset versus write collision:
  - Stimulus: r7 = 0xAA, then assert reset together with a write of 0x55 to r7.
  - Response: after the edge r7 reads 0 (not 0x55). wr_count = 0 and wr_onehot = 0 during the reset cycle.
- Counter saturation:
  - Stimulus: 65,540 back-to-back writes.
  - Response: wr_count reaches 0xFFFF and holds there. A subsequent reset returns it to 0.

Source files
------------

// File: rtl/regfile_write_decode.sv
// 32-entry register file with a one-hot write decoder, two combinational read
// ports, a hardwired-zero r0, optional write-to-read bypass and a saturating write counter.
module regfile_write_decode #(
    parameter int unsigned width  = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [width-1:0] rd_data_a,
    output logic [width-1:0] rd_data_b,
    output logic [31:0]      wr_onehot,
    output logic [15:0]      wr_count
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [width-1:0] regs_q [1:NUM_REGS-1];
    logic [width-1:0] regs_d [1:NUM_REGS-1];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic             wr_live;

    // A write is live only outside reset; r0 never gets a strobe.
    always_comb begin
        wr_live   = wr_en && !reset;
        wr_onehot = '0;
        for (int k = 1; k < NUM_REGS; k++) begin
            wr_onehot[k] = wr_live && (wr_addr == ADDR_W'(k));
        end
    end

    always_comb begin
        for (int k = 1; k < NUM_REGS; k++) begin
            regs_d[k] = wr_onehot[k] ? wr_data : regs_q[k];
        end
    end

    // The counter commits r0 writes too; they are architectural no-ops.
    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wr_count_q <= wr_count_d;
        end
    end

    // wr_onehot[0] is always 0, so an r0 read can never pick up a bypass.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (BYPASS && wr_onehot[rd_addr_a]) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = regs_q[rd_addr_b];
        end
        if (BYPASS && wr_onehot[rd_addr_b]) begin
            rd_data_b = wr_data;
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed bench: one instance without bypass and one with, driven in lockstep.
module tb_regfile_write_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_a0, rd_b0, oh0;
    logic [31:0] rd_a1, rd_b1, oh1;
    logic [15:0] cnt0, cnt1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    regfile_write_decode #(.width(32), .BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a0), .rd_data_b(rd_b0), .wr_onehot(oh0), .wr_count(cnt0)
    );

    regfile_write_decode #(.width(32), .BYPASS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a1), .rd_data_b(rd_b1), .wr_onehot(oh1), .wr_count(cnt1)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
        logic [31:0] eoh;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        reset     = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'(k) * 32'h0101_0101;
    endfunction

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd5,  32'h11,        5'd5,  5'd5,  32'h05050505, 32'h11,       32'h05050505, 32'h11,       32'h20,       16'd31};
        vecs[1] = '{1'b0, 1'b1, 5'd5,  32'h22,        5'd5,  5'd6,  32'h11,       32'h22,       32'h06060606, 32'h06060606, 32'h20,       16'd32};
        vecs[2] = '{1'b0, 1'b0, 5'd5,  32'hFFFFFFFF,  5'd5,  5'd5,  32'h22,       32'h22,       32'h22,       32'h22,       32'h0,        16'd33};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  32'h33,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd33};
        vecs[4] = '{1'b0, 1'b1, 5'd7,  32'hAA,        5'd7,  5'd9,  32'h07070707, 32'hAA,       32'h09090909, 32'h09090909, 32'h80,       16'd34};
        vecs[5] = '{1'b1, 1'b1, 5'd7,  32'h55,        5'd7,  5'd7,  32'hAA,       32'hAA,       32'hAA,       32'hAA,       32'h0,        16'd35};
        vecs[6] = '{1'b0, 1'b0, 5'd7,  32'h0,         5'd7,  5'd5,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd0};
        vecs[7] = '{1'b0, 1'b1, 5'd31, 32'h12345678,  5'd31, 5'd30, 32'h0,        32'h12345678, 32'h0,        32'h0,        32'h80000000, 16'd0};
        vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        16'd1};

        // Reset for two cycles, then sweep every address on both ports.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        check("reset_cnt0", 32'(cnt0), 32'h0);
        check("reset_cnt1", 32'(cnt1), 32'h0);
        check("reset_oh", oh0 | oh1, 32'h0);
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            rd_addr_b = 5'(31 - k);
            #1;
            check("reset_read_a", rd_a0 | rd_a1, 32'h0);
            check("reset_read_b", rd_b0 | rd_b1, 32'h0);
        end

        // Write to r0 is a counted no-op.
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        #2;
        check("r0_oh0", oh0, 32'h0);
        check("r0_oh1", oh1, 32'h0);
        check("r0_byp_a", rd_a1, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        check("r0_read_a0", rd_a0, 32'h0);
        check("r0_read_b1", rd_b1, 32'h0);
        check("r0_cnt0", 32'(cnt0), 32'h1);
        check("r0_cnt1", 32'(cnt1), 32'h1);

        // Decoder sweep from a clean reset.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 1'b1, 5'(k), pat(k), 5'(k), 5'(k - 1));
            #2;
            check("sweep_oh0", oh0, 32'h1 << k);
            check("sweep_oh1", oh1, 32'h1 << k);
            check("sweep_old_a0", rd_a0, 32'h0);
            check("sweep_byp_a1", rd_a1, pat(k));
            check("sweep_prev_b0", rd_b0, pat(k - 1));
            check("sweep_prev_b1", rd_b1, pat(k - 1));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        check("sweep_cnt0", 32'(cnt0), 32'd31);
        check("sweep_cnt1", 32'(cnt1), 32'd31);
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            rd_addr_b = 5'(31 - k);
            #1;
            check("sweep_rd_a0", rd_a0, pat(k));
            check("sweep_rd_a1", rd_a1, pat(k));
            check("sweep_rd_b0", rd_b0, pat(31 - k));
            check("sweep_rd_b1", rd_b1, pat(31 - k));
        end
        @(negedge clk);

        // Same-cycle read/write, r0 write, reset collision, top register.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
            #2;
            check($sformatf("vec%0d_a0", i), rd_a0, vecs[i].ea0);
            check($sformatf("vec%0d_a1", i), rd_a1, vecs[i].ea1);
            check($sformatf("vec%0d_b0", i), rd_b0, vecs[i].eb0);
            check($sformatf("vec%0d_b1", i), rd_b1, vecs[i].eb1);
            check($sformatf("vec%0d_oh0", i), oh0, vecs[i].eoh);
            check($sformatf("vec%0d_oh1", i), oh1, vecs[i].eoh);
            check($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].ecnt));
            @(negedge clk);
        end

        // Counter saturation over back-to-back writes, then reset.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd3, 32'hC0FFEE, 5'd3, 5'd0);
        repeat (65534) @(negedge clk);
        check("sat_pre_cnt", 32'(cnt0), 32'h0000FFFE);
        @(negedge clk);
        check("sat_cnt0", 32'(cnt0), 32'h0000FFFF);
        check("sat_cnt1", 32'(cnt1), 32'h0000FFFF);
        repeat (5) @(negedge clk);
        check("sat_hold0", 32'(cnt0), 32'h0000FFFF);
        check("sat_hold1", 32'(cnt1), 32'h0000FFFF);
        check("sat_data", rd_a0, 32'hC0FFEE);
        drive(1'b1, 1'b1, 5'd3, 32'h1, 5'd3, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        #2;
        check("sat_reset_cnt0", 32'(cnt0), 32'h0);
        check("sat_reset_cnt1", 32'(cnt1), 32'h0);
        check("sat_reset_data", rd_a0 | rd_a1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
